instruction_decode_stage: RTL and testbench

Decode stage of the 5-stage ARM pipeline, located between the IF→ID and ID→EXE pipeline registers. Each cycle it decodes one 32-bit ARM instruction (data-processing, LDR/STR, B), evaluates its condition against the current NZCV status, reads operands from a 15-entry register file, and produces the control and data bundle captured by the ID→EXE register. The register file is written by the write-back stage. Source-register information is exported to the hazard unit.

---
 rtl/instruction_decode_stage_pkg.sv | 87 ++++++++
 rtl/instruction_decode_stage_if.sv | 36 +++
 rtl/instruction_decode_stage_register_file.sv | 23 ++
 rtl/instruction_decode_stage.sv | 65 ++++++
 tb/tb_instruction_decode_stage.sv | 133 +++++++++++++
 5 files changed

// File: rtl/instruction_decode_stage_pkg.sv
// arm_defs: shared ARM encodings, execute commands and condition evaluation
package arm_defs;
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v, r;
    {n, z, cf, v} = nzcv;
    r = 1'b0;
    case (c)
      COND_EQ: r = z;
      COND_NE: r = !z;
      COND_CS: r = cf;
      COND_CC: r = !cf;
      COND_MI: r = n;
      COND_PL: r = !n;
      COND_VS: r = v;
      COND_VC: r = !v;
      COND_HI: r = cf && !z;
      COND_LS: r = !cf || z;
      COND_GE: r = n == v;
      COND_LT: r = n != v;
      COND_GT: r = !z && (n == v);
      COND_LE: r = z || (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] dp_cmd(input logic [3:0] op);
    logic [3:0] r;
    r = EXE_NOP;
    case (op)
      OP_MOV: r = EXE_MOV;
      OP_MVN: r = EXE_MVN;
      OP_ADD: r = EXE_ADD;
      OP_ADC: r = EXE_ADC;
      OP_SUB: r = EXE_SUB;
      OP_SBC: r = EXE_SBC;
      OP_AND: r = EXE_AND;
      OP_ORR: r = EXE_ORR;
      OP_EOR: r = EXE_EOR;
      OP_CMP: r = EXE_SUB;
      OP_TST: r = EXE_AND;
      default: r = EXE_NOP;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/instruction_decode_stage_if.sv
// instruction_decode_stage_if: decode-stage inputs and ID->EXE bundle
interface instruction_decode_stage_if;
  logic [31:0] instruction;
  logic [31:0] PCIn;
  logic        freeze;
  logic [3:0]  statusIn;
  logic        wbEn;
  logic [3:0]  wbDest;
  logic [31:0] wbValue;
  logic        writeBackEn;
  logic        memRead;
  logic        memWrite;
  logic        s;
  logic        branch;
  logic [3:0]  executeCommand;
  logic        immediate;
  logic [31:0] PC;
  logic [31:0] reg1Val;
  logic [31:0] reg2Val;
  logic [11:0] shiftOperand;
  logic [23:0] signedImmediate;
  logic [3:0]  destination;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        twoSrc;
  modport master (
    output instruction, PCIn, freeze, statusIn, wbEn, wbDest, wbValue,
    input  writeBackEn, memRead, memWrite, s, branch, executeCommand, immediate, PC,
           reg1Val, reg2Val, shiftOperand, signedImmediate, destination, src1, src2, twoSrc
  );
  modport slave (
    input  instruction, PCIn, freeze, statusIn, wbEn, wbDest, wbValue,
    output writeBackEn, memRead, memWrite, s, branch, executeCommand, immediate, PC,
           reg1Val, reg2Val, shiftOperand, signedImmediate, destination, src1, src2, twoSrc
  );
endinterface

// File: rtl/instruction_decode_stage_register_file.sv
// register_file: R0-R14 with write-through bypass; index 15 reads the PC
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic        we,
  input  logic [3:0]  wa,
  input  logic [31:0] wd,
  input  logic [31:0] pc,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] r [15];
  logic wr;
  assign wr = we && wa != 4'd15;
  // reset clears everything and wins over a same-edge write; writes to 15 are dropped
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < 15; i++) r[i] <= '0;
    else if (wr) r[wa] <= wd;
  assign rd1 = ra1 == 4'd15 ? pc : (wr && wa == ra1) ? wd : r[ra1];
  assign rd2 = ra2 == 4'd15 ? pc : (wr && wa == ra2) ? wd : r[ra2];
endmodule

// File: rtl/instruction_decode_stage.sv
// instruction_decode_stage: combinational ARM decode, condition check and operand read
module instruction_decode_stage
  import arm_defs::*;
(
  input logic clk,
  input logic rst,
  instruction_decode_stage_if.slave bus
);
  logic [31:0] ins;
  logic [1:0]  mode;
  logic [3:0]  op, cmd;
  logic        sbit, ibit, str, en, wb, mr, mw, sf, br;
  assign ins  = bus.instruction;
  assign mode = ins[27:26];
  assign op   = ins[24:21];
  assign sbit = ins[20];
  assign ibit = ins[25];
  assign str  = mode == MODE_MEM && !sbit;
  assign en   = cond_pass(ins[31:28], bus.statusIn) && !bus.freeze;
  // raw control per instruction class, before condition/freeze gating
  always_comb begin
    cmd = EXE_NOP;
    wb  = 1'b0;
    mr  = 1'b0;
    mw  = 1'b0;
    sf  = 1'b0;
    br  = 1'b0;
    if (mode == MODE_DP) begin
      cmd = dp_cmd(op);
      wb  = cmd != EXE_NOP && op != OP_CMP && op != OP_TST;
      sf  = cmd != EXE_NOP && sbit;
    end else if (mode == MODE_MEM) begin
      cmd = EXE_ADD;
      wb  = sbit;
      mr  = sbit;
      mw  = !sbit;
    end else if (mode == MODE_BR) br = 1'b1;
  end
  assign bus.executeCommand  = en ? cmd : EXE_NOP;
  assign bus.writeBackEn     = en && wb;
  assign bus.memRead         = en && mr;
  assign bus.memWrite        = en && mw;
  assign bus.s               = en && sf;
  assign bus.branch          = en && br;
  assign bus.immediate       = ibit;
  assign bus.PC              = bus.PCIn;
  assign bus.shiftOperand    = ins[11:0];
  assign bus.signedImmediate = ins[23:0];
  assign bus.destination     = ins[15:12];
  assign bus.src1            = ins[19:16];
  assign bus.src2            = str ? ins[15:12] : ins[3:0];
  assign bus.twoSrc          = (mode == MODE_DP && !ibit) || str;
  register_file u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (bus.src1),
    .ra2 (bus.src2),
    .we  (bus.wbEn),
    .wa  (bus.wbDest),
    .wd  (bus.wbValue),
    .pc  (bus.PCIn),
    .rd1 (bus.reg1Val),
    .rd2 (bus.reg2Val)
  );
endmodule

// File: tb/tb_instruction_decode_stage.sv
// tb_instruction_decode_stage: directed checks of decode, conditions and register file
module tb_instruction_decode_stage;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  instruction_decode_stage_if bus ();
  instruction_decode_stage dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    bus.instruction = 32'hE0832004;
    bus.PCIn = 32'h0000_0040;
    bus.freeze = 1'b0;
    bus.statusIn = 4'b0000;
    bus.wbEn = 1'b0;
    bus.wbDest = 4'd0;
    bus.wbValue = 32'd0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_r3", bus.reg1Val, 32'h0);
    chk("reset_r4", bus.reg2Val, 32'h0);
    bus.wbEn = 1'b1; bus.wbDest = 4'd3; bus.wbValue = 32'hAA;
    tick();
    bus.wbEn = 1'b0;
    #1;
    chk("add_reg1", bus.reg1Val, 32'hAA);
    chk("add_cmd", bus.executeCommand, 4'b0010);
    chk("add_wb", bus.writeBackEn, 1'b1);
    chk("add_two", bus.twoSrc, 1'b1);
    chk("add_src1", bus.src1, 4'd3);
    chk("add_src2", bus.src2, 4'd4);
    chk("add_dest", bus.destination, 4'd2);
    chk("add_pc", bus.PC, 32'h40);
    chk("add_mem", {bus.memRead, bus.memWrite, bus.branch, bus.s}, 4'b0000);
    bus.instruction = 32'hE0812004;
    bus.wbEn = 1'b1; bus.wbDest = 4'd1; bus.wbValue = 32'h1234;
    #1;
    chk("bypass_same_cycle", bus.reg1Val, 32'h1234);
    tick();
    bus.wbEn = 1'b0;
    #1;
    chk("bypass_stored", bus.reg1Val, 32'h1234);
    bus.instruction = 32'h0A000003; bus.statusIn = 4'b0000;
    #1;
    chk("beq_not_taken", bus.branch, 1'b0);
    bus.statusIn = 4'b0100;
    #1;
    chk("beq_taken", bus.branch, 1'b1);
    chk("beq_simm", bus.signedImmediate, 24'h000003);
    chk("beq_wb", bus.writeBackEn, 1'b0);
    bus.statusIn = 4'b0000;
    bus.instruction = 32'hE5842000;
    #1;
    chk("str_memw", bus.memWrite, 1'b1);
    chk("str_wb", bus.writeBackEn, 1'b0);
    chk("str_two", bus.twoSrc, 1'b1);
    chk("str_src2", bus.src2, 4'd2);
    chk("str_cmd", bus.executeCommand, 4'b0010);
    bus.instruction = 32'hE5942000;
    #1;
    chk("ldr_memr", bus.memRead, 1'b1);
    chk("ldr_wb", bus.writeBackEn, 1'b1);
    chk("ldr_memw", bus.memWrite, 1'b0);
    chk("ldr_two", bus.twoSrc, 1'b0);
    chk("ldr_s", bus.s, 1'b0);
    bus.instruction = 32'hE1530004;
    #1;
    chk("cmp_cmd", bus.executeCommand, 4'b0100);
    chk("cmp_wb", bus.writeBackEn, 1'b0);
    chk("cmp_s", bus.s, 1'b1);
    bus.instruction = 32'hE3A01005;
    #1;
    chk("mov_cmd", bus.executeCommand, 4'b0001);
    chk("mov_imm", bus.immediate, 1'b1);
    chk("mov_two", bus.twoSrc, 1'b0);
    chk("mov_shop", bus.shiftOperand, 12'h005);
    bus.instruction = 32'hE0632004;
    #1;
    chk("undef_ctrl", {bus.executeCommand, bus.writeBackEn, bus.s}, 6'b0);
    bus.instruction = 32'hC0832004;
    #1;
    chk("gt_taken", bus.executeCommand, 4'b0010);
    bus.statusIn = 4'b1000;
    #1;
    chk("gt_not_taken", bus.executeCommand, 4'b0000);
    bus.instruction = 32'h90832004; bus.statusIn = 4'b0010;
    #1;
    chk("ls_false", bus.writeBackEn, 1'b0);
    bus.instruction = 32'hF0832004; bus.statusIn = 4'b0000;
    #1;
    chk("nv_never", bus.writeBackEn, 1'b0);
    bus.instruction = 32'hE0832004; bus.freeze = 1'b1;
    #1;
    chk("freeze_ctrl", {bus.executeCommand, bus.writeBackEn, bus.memRead, bus.memWrite, bus.s, bus.branch}, 9'b0);
    chk("freeze_reg1", bus.reg1Val, 32'hAA);
    bus.freeze = 1'b0;
    bus.instruction = 32'hE08F2004;
    bus.wbEn = 1'b1; bus.wbDest = 4'd15; bus.wbValue = 32'hDEAD;
    #1;
    chk("r15_wb_same_cycle", bus.reg1Val, 32'h40);
    tick();
    bus.wbEn = 1'b0;
    #1;
    chk("r15_reads_pc", bus.reg1Val, 32'h40);
    bus.instruction = 32'hE0832004;
    rst = 1'b1; bus.wbEn = 1'b1; bus.wbDest = 4'd3; bus.wbValue = 32'h99;
    #1;
    chk("rst_bypass", bus.reg1Val, 32'h99);
    tick();
    rst = 1'b0; bus.wbEn = 1'b0;
    #1;
    chk("rst_over_write", bus.reg1Val, 32'h0);
    bus.instruction = 32'hE0812004;
    #1;
    chk("rst_r1_clear", bus.reg1Val, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
